gps_query_sched: RTL and testbench

//  Schedules GPS queries 0..NUM_Q-1 (hw version, valid, sats, time, date, lat, lon, alt, speed,

---
 rtl/gps_query_sched.sv | 174 +++++++++++++++++
 tb/tb_gps_query_sched.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_query_sched.sv
// Round-robin scheduler feeding periodic and forced GPS queries into a single-transaction engine.
// Define GPS_SCHED_WATCHDOG_EN to add a tick-based watchdog that converts a silent engine into a timeout.
module gps_query_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       wr,
  input  logic [7:0] wr_data,
  output logic       hit
);
  logic [7:0] period, cdown;

  // A write reloads the countdown and overrides a coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period <= '0;
      cdown  <= '0;
    end else if (wr) begin
      period <= wr_data;
      cdown  <= wr_data;
    end else if (tick && period != 8'd0) begin
      cdown <= (cdown <= 8'd1) ? period : cdown - 8'd1;
    end
  end

  assign hit = tick && !wr && (period != 8'd0) && (cdown <= 8'd1);
endmodule

module gps_query_sched #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 10,
  parameter int NUM_Q     = 10,
  parameter int MAX_RETRY = 3,
  parameter int WD_TICKS  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             period_wr,
  input  logic [3:0]       period_addr,
  input  logic [7:0]       period_data,
  input  logic [NUM_Q-1:0] force_req,
  output logic             q_valid,
  output logic [3:0]       q_cmd,
  input  logic             q_ack,
  input  logic             q_done,
  input  logic             q_timeout,
  output logic             busy,
  output logic [NUM_Q-1:0] pending,
  output logic [NUM_Q-1:0] stale,
  output logic             wd_fire
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int RW       = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [NUM_Q-1:0] hit, g_oh, clr_vec;
  logic [3:0]       last, gnt;
  logic             found;
  int               idx;
  logic [RW-1:0]    retry, retry_new;
  logic             done_ev, to_ev, give_up, wd_exp;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc <= '0;
    else      presc <= tick ? '0 : presc + PW'(1);
  end

  for (genvar i = 0; i < NUM_Q; i++) begin : g_slot
    gps_query_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .wr      (period_wr && period_addr == 4'(i)),
      .wr_data (period_data),
      .hit     (hit[i])
    );
  end

  // First pending slot strictly after the last grant, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = last;
    idx   = 0;
    for (int k = 1; k <= NUM_Q; k++) begin
      idx = (int'(last) + k) % NUM_Q;
      if (!found && pending[idx]) begin
        found = 1'b1;
        gnt   = 4'(idx);
      end
    end
  end

  assign g_oh      = NUM_Q'(1) << q_cmd;
  assign retry_new = retry + RW'(1);
  assign done_ev   = (state == S_WAIT) && q_done;
  assign to_ev     = (state == S_WAIT) && !q_done && (q_timeout || wd_exp);
  assign give_up   = to_ev && (retry_new >= RW'(MAX_RETRY));
  assign clr_vec   = (done_ev || give_up) ? g_oh : '0;
  assign busy      = (state != S_IDLE);

  // New requests win over a same-cycle completion clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= (pending & ~clr_vec) | hit | force_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      q_valid <= 1'b0;
      q_cmd   <= '0;
      last    <= 4'(NUM_Q - 1);
      retry   <= '0;
      stale   <= '0;
    end else begin
      case (state)
        S_IDLE: if (enable && found) begin
          q_cmd   <= gnt;
          q_valid <= 1'b1;
          last    <= gnt;
          state   <= S_ISSUE;
        end
        S_ISSUE: if (q_ack) begin
          q_valid <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: if (done_ev) begin
          stale <= stale & ~g_oh;
          retry <= '0;
          state <= S_IDLE;
        end else if (to_ev) begin
          if (give_up) begin
            stale <= stale | g_oh;
            retry <= '0;
          end else begin
            retry <= retry_new;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GPS_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WD_TICKS + 1);
  logic [WW-1:0] wd_cnt;

  assign wd_exp = (state == S_WAIT) && tick && (wd_cnt == WW'(WD_TICKS - 1)) && !q_done && !q_timeout;

  // Counter sits at zero outside WAIT, so every WAIT entry starts a fresh window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt  <= '0;
      wd_fire <= 1'b0;
    end else begin
      wd_fire <= wd_exp;
      if (state != S_WAIT) wd_cnt <= '0;
      else if (tick)       wd_cnt <= wd_cnt + WW'(1);
    end
  end
`else
  assign wd_exp  = 1'b0;
  assign wd_fire = 1'b0;
`endif
endmodule

// File: tb/tb_gps_query_sched.sv
// Bench for gps_query_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_gps_query_sched;
  localparam int NQ   = 10;
  localparam int TDIV = 10;
  localparam int MAXR = 3;
  localparam int WDT  = 2;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0, period_wr = 1'b0;
  logic [3:0]    period_addr = '0;
  logic [7:0]    period_data = '0;
  logic [NQ-1:0] force_req = '0;
  logic          q_ack = 1'b0, q_done = 1'b0, q_timeout = 1'b0;
  logic          q_valid, busy, wd_fire;
  logic [3:0]    q_cmd;
  logic [NQ-1:0] pending, stale;
  int            n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  gps_query_sched #(
    .CLK_HZ(1000), .TICK_HZ(100), .NUM_Q(NQ), .MAX_RETRY(MAXR), .WD_TICKS(WDT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .period_wr(period_wr), .period_addr(period_addr),
    .period_data(period_data), .force_req(force_req), .q_valid(q_valid), .q_cmd(q_cmd),
    .q_ack(q_ack), .q_done(q_done), .q_timeout(q_timeout), .busy(busy), .pending(pending),
    .stale(stale), .wd_fire(wd_fire)
  );

  // Reference model state
  int          m_presc, m_state, m_cmd, m_last, m_retry, m_wd;
  int          m_period[NQ], m_cd[NQ];
  bit [NQ-1:0] m_pend, m_stale;
  bit          m_valid, m_wdf;

  task automatic model_reset();
    m_presc = 0; m_state = M_IDLE; m_cmd = 0; m_last = NQ - 1; m_retry = 0; m_wd = 0;
    m_pend = '0; m_stale = '0; m_valid = 0; m_wdf = 0;
    for (int i = 0; i < NQ; i++) begin m_period[i] = 0; m_cd[i] = 0; end
  endtask

  task automatic model_step();
    bit tick, to_ev;
    bit [NQ-1:0] set_v, clr_v;
    tick = (m_presc == TDIV - 1);
    m_presc = tick ? 0 : m_presc + 1;
    set_v = force_req;
    clr_v = '0;
    m_wdf = 0;
    for (int i = 0; i < NQ; i++) begin
      if (period_wr && period_addr == i) begin
        m_period[i] = period_data; m_cd[i] = period_data;
      end else if (tick && m_period[i] != 0) begin
        if (m_cd[i] <= 1) begin set_v[i] = 1; m_cd[i] = m_period[i]; end
        else m_cd[i]--;
      end
    end
    case (m_state)
      M_IDLE: if (enable && m_pend != 0) begin
        for (int k = 1; k <= NQ; k++)
          if (m_pend[(m_last + k) % NQ]) begin m_cmd = (m_last + k) % NQ; break; end
        m_last = m_cmd; m_valid = 1; m_state = M_ISSUE;
      end
      M_ISSUE: if (q_ack) begin m_valid = 0; m_state = M_WAIT; m_wd = 0; end
      default: begin
        to_ev = q_timeout;
`ifdef GPS_SCHED_WATCHDOG_EN
        if (tick) m_wd++;
        if (tick && m_wd == WDT && !q_done && !q_timeout) begin to_ev = 1; m_wdf = 1; end
`endif
        if (q_done) begin
          clr_v[m_cmd] = 1; m_stale[m_cmd] = 0; m_retry = 0; m_state = M_IDLE;
        end else if (to_ev) begin
          m_retry++;
          if (m_retry >= MAXR) begin clr_v[m_cmd] = 1; m_stale[m_cmd] = 1; m_retry = 0; end
          m_state = M_IDLE;
        end
      end
    endcase
    m_pend = (m_pend & ~clr_v) | set_v;
  endtask

  // Advance one clock; inputs are held across the edge, outputs settle by the #1.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 0; enable = 0; period_wr = 0; period_addr = 0; period_data = 0; force_req = '0;
    q_ack = 0; q_done = 0; q_timeout = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 0; enable = 1; force_req = '1; q_ack = 1; q_done = 1; period_wr = 1; period_data = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({q_valid, q_cmd, busy, pending, stale, wd_fire} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got v=%b cmd=%0d busy=%b pend=%h stale=%h wd=%b, want all 0",
               q_valid, q_cmd, busy, pending, stale, wd_fire);
    end
    do_reset();
    repeat (12) cycle();
    n_vec++;
    if ({q_valid, q_cmd, busy, pending, stale, wd_fire} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got v=%b cmd=%0d busy=%b pend=%h stale=%h, want all 0",
               q_valid, q_cmd, busy, pending, stale);
    end
  endtask

  task automatic test_periodic();
    int rises[$];
    bit pv = 0, cmd_ok = 1;
    do_reset();
    enable = 1;
    period_wr = 1; period_addr = 4'd3; period_data = 8'd2;
    cycle();
    period_wr = 0;
    for (int c = 0; c < 75; c++) begin
      q_ack = q_valid; q_done = busy && !q_valid;
      cycle();
      if (q_valid && !pv) begin rises.push_back(c); if (q_cmd !== 4'd3) cmd_ok = 0; end
      pv = q_valid;
    end
    q_ack = 0; q_done = 0;
    n_vec++;
    if (rises.size() != 3) begin
      n_err++; $display("FAIL periodic_count: got %0d issues, want 3", rises.size());
    end else begin
      n_vec++;
      if (rises[0] != 19) begin n_err++; $display("FAIL periodic_first: got cycle %0d, want 19", rises[0]); end
      n_vec++;
      if (rises[1] - rises[0] != 20 || rises[2] - rises[1] != 20) begin
        n_err++; $display("FAIL periodic_spacing: got %0d/%0d, want 20/20", rises[1] - rises[0], rises[2] - rises[1]);
      end
    end
    n_vec++;
    if (!cmd_ok) begin n_err++; $display("FAIL periodic_cmd: an issue had q_cmd != 3"); end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int exp_g[4] = '{0, 2, 9, 0};
    bit pv = 0, inject = 0;
    do_reset();
    enable = 1;
    force_req = 10'h205;
    cycle();
    force_req = '0;
    for (int c = 0; c < 40; c++) begin
      q_ack = q_valid; q_done = busy && !q_valid;
      force_req = inject ? 10'h001 : 10'h000;
      inject = 0;
      cycle();
      if (q_valid && !pv) begin grants.push_back(int'(q_cmd)); if (q_cmd == 4'd2) inject = 1; end
      pv = q_valid;
    end
    q_ack = 0; q_done = 0; force_req = '0;
    n_vec++;
    if (grants.size() != 4) begin
      n_err++; $display("FAIL rr_count: got %0d grants, want 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (grants[i] != exp_g[i]) begin
          n_err++; $display("FAIL rr_order[%0d]: got %0d, want %0d", i, grants[i], exp_g[i]);
        end
      end
    end
    n_vec++;
    if ({q_valid, busy, pending} !== {m_valid, m_state != M_IDLE, m_pend}) begin
      n_err++; $display("FAIL rr_model: got pend=%h busy=%b, want pend=%h busy=%b", pending, busy, m_pend, m_state != M_IDLE);
    end
  endtask

  task automatic test_retry();
    int n5 = 0, nall = 0;
    bit pv = 0;
    do_reset();
    enable = 1;
    force_req = 10'h020;
    cycle();
    force_req = '0;
    for (int c = 0; c < 30; c++) begin
      q_ack = q_valid; q_timeout = busy && !q_valid;
      cycle();
      if (q_valid && !pv) begin nall++; if (q_cmd == 4'd5) n5++; end
      pv = q_valid;
    end
    q_ack = 0; q_timeout = 0;
    n_vec++;
    if (n5 != 3 || nall != 3) begin n_err++; $display("FAIL retry_issues: got %0d (slot5 %0d), want 3", nall, n5); end
    n_vec++;
    if (stale !== 10'h020 || pending !== 10'h000 || busy !== 1'b0) begin
      n_err++; $display("FAIL retry_stale: got stale=%h pend=%h busy=%b, want 020/000/0", stale, pending, busy);
    end
    force_req = 10'h020;
    cycle();
    force_req = '0;
    for (int c = 0; c < 10; c++) begin
      q_ack = q_valid; q_done = busy && !q_valid;
      cycle();
    end
    q_ack = 0; q_done = 0;
    n_vec++;
    if (stale !== 10'h000 || pending !== 10'h000) begin
      n_err++; $display("FAIL retry_recover: got stale=%h pend=%h, want 000/000", stale, pending);
    end
  endtask

  task automatic test_done_and_timeout();
    int nw = 0, nr = 0;
    bit pv = 0;
    do_reset();
    enable = 1;
    force_req = 10'h010;
    cycle();
    force_req = '0;
    for (int c = 0; c < 20; c++) begin
      q_ack = q_valid;
      if (busy && !q_valid) begin q_timeout = 1; q_done = (nw > 0); nw++; end
      else begin q_timeout = 0; q_done = 0; end
      cycle();
      if (q_valid && !pv) nr++;
      pv = q_valid;
    end
    q_ack = 0; q_done = 0; q_timeout = 0;
    n_vec++;
    if (nr != 2 || pending !== 10'h000 || stale !== 10'h000) begin
      n_err++; $display("FAIL done_wins: got issues=%0d pend=%h stale=%h, want 2/000/000", nr, pending, stale);
    end
    // Retry count must have restarted: three fresh timeouts are needed to go stale.
    nr = 0; pv = 0;
    force_req = 10'h010;
    cycle();
    force_req = '0;
    for (int c = 0; c < 30; c++) begin
      q_ack = q_valid; q_timeout = busy && !q_valid;
      cycle();
      if (q_valid && !pv) nr++;
      pv = q_valid;
    end
    q_ack = 0; q_timeout = 0;
    n_vec++;
    if (nr != 3 || stale !== 10'h010) begin
      n_err++; $display("FAIL done_retry_reset: got issues=%0d stale=%h, want 3/010", nr, stale);
    end
  endtask

  task automatic test_enable_gate();
    bit reached = 0, leaked = 0, pv = 0;
    int first = -1;
    do_reset();
    enable = 1;
    force_req = 10'h002;
    cycle();
    force_req = '0;
    for (int c = 0; c < 10 && !reached; c++) begin
      q_ack = q_valid;
      cycle();
      if (busy && !q_valid) reached = 1;
    end
    n_vec++;
    if (!reached) begin n_err++; $display("FAIL gate_wait: never reached WAIT within 10 cycles"); end
    q_ack = 0; enable = 0; force_req = '1; q_done = 1;
    cycle();
    force_req = '0; q_done = 0;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (q_valid) leaked = 1;
    end
    n_vec++;
    if (leaked || busy !== 1'b0 || pending !== 10'h3FF) begin
      n_err++; $display("FAIL gate_hold: got leak=%b busy=%b pend=%h, want 0/0/3ff", leaked, busy, pending);
    end
    enable = 1;
    for (int c = 0; c < 10; c++) begin
      q_ack = q_valid; q_done = busy && !q_valid;
      cycle();
      if (q_valid && !pv && first < 0) first = int'(q_cmd);
      pv = q_valid;
    end
    q_ack = 0; q_done = 0;
    n_vec++;
    if (first != 2) begin n_err++; $display("FAIL gate_resume: got first grant %0d, want 2", first); end
  endtask

  task automatic test_watchdog();
    bit fired = 0, retried = 0, pv = 1;
    int t_wait = -1, t_fire = -1;
    do_reset();
    enable = 1;
    force_req = 10'h080;
    cycle();
    force_req = '0;
    for (int c = 0; c < 100; c++) begin
      q_ack = q_valid;
      cycle();
      if (busy && !q_valid && t_wait < 0) t_wait = c;
      if (wd_fire && !fired) begin fired = 1; t_fire = c; end
      if (fired && q_valid && !pv && q_cmd == 4'd7) retried = 1;
      pv = q_valid;
    end
    q_ack = 0;
`ifdef GPS_SCHED_WATCHDOG_EN
    n_vec++;
    if (!fired || !retried) begin n_err++; $display("FAIL wd_fire: got fired=%b retried=%b, want 1/1", fired, retried); end
    n_vec++;
    if (fired && (t_fire - t_wait < 10 || t_fire - t_wait > 21)) begin
      n_err++; $display("FAIL wd_delay: got %0d cycles in WAIT, want 10..21", t_fire - t_wait);
    end
`else
    n_vec++;
    if (fired || busy !== 1'b1 || q_valid !== 1'b0 || t_wait < 0) begin
      n_err++; $display("FAIL wd_absent: got fired=%b busy=%b valid=%b, want 0/1/0", fired, busy, q_valid);
    end
`endif
  endtask

  task automatic test_midflight_reset();
    bit seen = 0;
    do_reset();
    enable = 1;
    force_req = 10'h040;
    cycle();
    force_req = '0;
    for (int c = 0; c < 5 && !seen; c++) begin cycle(); if (q_valid) seen = 1; end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL midrst_issue: q_valid never rose"); end
    #2;
    rst = 0;
    #1;
    n_vec++;
    if (q_valid !== 1'b0 || busy !== 1'b0 || pending !== 10'h000) begin
      n_err++; $display("FAIL midrst_async: got v=%b busy=%b pend=%h, want 0/0/000", q_valid, busy, pending);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      q_ack = $urandom_range(0, 1);
      q_done = ($urandom_range(0, 3) == 0);
      q_timeout = ($urandom_range(0, 2) == 0);
      period_wr = ($urandom_range(0, 19) == 0);
      period_addr = 4'($urandom_range(0, 15));
      period_data = 8'($urandom_range(0, 4));
      for (int i = 0; i < NQ; i++) force_req[i] = ($urandom_range(0, 24) == 0);
      cycle();
      n_vec++;
      if ({q_valid, q_cmd, busy, pending, stale, wd_fire} !==
          {m_valid, 4'(m_cmd), m_state != M_IDLE, m_pend, m_stale, m_wdf}) begin
        n_err++;
        $display("FAIL random c=%0d: got v=%b cmd=%0d busy=%b pend=%h stale=%h wd=%b, want v=%b cmd=%0d busy=%b pend=%h stale=%h wd=%b",
                 c, q_valid, q_cmd, busy, pending, stale, wd_fire,
                 m_valid, m_cmd, m_state != M_IDLE, m_pend, m_stale, m_wdf);
      end
    end
    enable = 0; q_ack = 0; q_done = 0; q_timeout = 0; period_wr = 0; force_req = '0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_round_robin();
    test_retry();
    test_done_and_timeout();
    test_enable_gate();
    test_watchdog();
    test_midflight_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
